// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM states, default width.
// Op-code values track the ALU control decoder outputs.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iterative_exec_if.sv
// Request/response handshake bundle for alu_iterative_exec.
// slave = execution unit, master = issuing datapath.
interface alu_iterative_exec_if #(
  parameter int DATA_WIDTH = alu_pkg::ALU_DATA_WIDTH
);

  logic                  valid_i;
  logic                  ready_o;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;

  modport slave (
    input  valid_i, ALU_Operation_i,
    input  A_i, B_i, ready_i,
    output ready_o, valid_o,
    output ALU_Result_o, Zero_o
  );

  modport master (
    output valid_i, ALU_Operation_i,
    output A_i, B_i, ready_i,
    input  ready_o, valid_o,
    input  ALU_Result_o, Zero_o
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// Bit-serial logical shifter, one bit per cycle.
// done is high in the cycle whose q_next is the final value.
module alu_serial_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   dir,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [DATA_WIDTH-1:0]  q_next,
  output logic                   done
);

  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   left;

  assign q_next = left ? {work[DATA_WIDTH-2:0], 1'b0}
                       : {1'b0, work[DATA_WIDTH-1:1]};
  assign done   = (cnt == SHAMT_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work <= '0;
      cnt  <= '0;
      left <= 1'b0;
    end else if (load) begin
      work <= data;
      cnt  <= shamt;
      left <= dir;
    end else if (cnt != '0) begin
      work <= q_next;
      cnt  <= cnt - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_iterative_exec.sv
// Multicycle ALU execution unit with valid/ready request and result.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts.
module alu_iterative_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = 5
) (
  input logic            clk,
  input logic            reset,
  alu_iterative_exec_if.slave bus
);

  alu_state_e state, state_nxt;

  logic [DATA_WIDTH-1:0]  result, res_nxt;
  logic                   zero, zero_nxt;
  logic [DATA_WIDTH-1:0]  comb_res;
  logic [DATA_WIDTH-1:0]  sh_next;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   sh_done;
  logic                   sh_load;
  logic                   serial_go;
  logic [3:0]             op;

  assign op    = bus.ALU_Operation_i;
  assign shamt = bus.B_i[SHAMT_WIDTH-1:0];

  always_comb begin
    comb_res = '0;
    case (op)
      ALU_ADD: comb_res = bus.A_i + bus.B_i;
      ALU_SUB: comb_res = bus.A_i - bus.B_i;
      ALU_AND: comb_res = bus.A_i & bus.B_i;
      ALU_OR:  comb_res = bus.A_i | bus.B_i;
      ALU_XOR: comb_res = bus.A_i ^ bus.B_i;
      ALU_LUI: comb_res = {bus.B_i[DATA_WIDTH-1:12], 12'h000};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SRL: comb_res = bus.A_i >> shamt;
      ALU_SLL: comb_res = bus.A_i << shamt;
`else
      // only reached with shamt == 0
      ALU_SRL, ALU_SLL: comb_res = bus.A_i;
`endif
      default: comb_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign serial_go = 1'b0;
  assign sh_done   = 1'b0;
  assign sh_next   = '0;
`else
  assign serial_go = ((op == ALU_SRL) || (op == ALU_SLL))
                  && (shamt != '0);

  alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (sh_load),
    .dir    (op == ALU_SLL),
    .shamt  (shamt),
    .data   (bus.A_i),
    .q_next (sh_next),
    .done   (sh_done)
  );
`endif

  always_comb begin
    state_nxt = state;
    res_nxt   = result;
    zero_nxt  = zero;
    sh_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.valid_i) begin
          if (serial_go) begin
            sh_load   = 1'b1;
            state_nxt = SHIFT;
          end else begin
            res_nxt   = comb_res;
            zero_nxt  = (comb_res == '0);
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        if (sh_done) begin
          res_nxt   = sh_next;
          zero_nxt  = (sh_next == '0);
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state  <= state_nxt;
      result <= res_nxt;
      zero   <= zero_nxt;
    end
  end

  assign bus.ready_o      = (state == IDLE);
  assign bus.valid_o      = (state == DONE);
  assign bus.ALU_Result_o = result;
  assign bus.Zero_o       = zero;

endmodule
